// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings for the memory-access stage
package riscv_pkg;

  // ctrl_mem_op encoding
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;
  localparam logic [1:0] MEM_RSVD  = 2'b11;

  // load/store width codes (stores reuse the low three load codes)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // lane masks before shifting by the byte offset
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // width code is defined for the direction and the offset is naturally aligned
  function automatic logic mem_legal(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] off);
    case (f3)
      F3_LB:   mem_legal = 1'b1;
      F3_LH:   mem_legal = !off[0];
      F3_LW:   mem_legal = (off == 2'b00);
      F3_LBU:  mem_legal = !is_store;
      F3_LHU:  mem_legal = !is_store && !off[0];
      default: mem_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - load extraction/extension and store lane replication
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // pick the addressed lane of the read word and extend it; replicate store data
  always_comb begin
    byte_sel    = 8'(rdata_i >> {off_i, 3'b000});
    half_sel    = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_data_o = rdata_i;
    wdata_o     = store_data_i;
    byte_en_o   = BE_WORD;
    case (funct3_i)
      F3_LB: begin
        load_data_o = {{24{byte_sel[7]}}, byte_sel};
        wdata_o     = {4{store_data_i[7:0]}};
        byte_en_o   = BE_BYTE << off_i;
      end
      F3_LH: begin
        load_data_o = {{16{half_sel[15]}}, half_sel};
        wdata_o     = {2{store_data_i[15:0]}};
        byte_en_o   = BE_HALF << off_i;
      end
      F3_LBU:  load_data_o = {24'h0, byte_sel};
      F3_LHU:  load_data_o = {16'h0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - pipeline memory stage with dcache handshake and writeback registers
module memory_access
  import riscv_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_rst_n,
  input  logic        ctrl_stall,
  input  logic [31:0] res,
  input  logic [31:0] store_data,
  input  logic [1:0]  ctrl_mem_op,
  input  logic [2:0]  ctrl_mem_funct3,
  input  logic        ctrl_is_nop,
  input  logic        ctrl_wb,
  input  logic [4:0]  rd,
  output logic [31:0] dcache_addr,
  output logic        dcache_req,
  output logic        dcache_wen,
  output logic [3:0]  dcache_byte_en,
  output logic [31:0] dcache_wdata,
  input  logic [31:0] dcache_rdata,
  input  logic        dcache_rdy,
  output logic        ctrl_mem_stall,
  output logic [31:0] wb_data_reg,
  output logic [4:0]  wb_rd_reg,
  output logic        ctrl_wb_reg,
  output logic        ctrl_mem_fault_reg
);

  localparam logic [15:0] LIM_C = 16'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  state_e      state_q, state_d;
  logic        timeout;
  logic        req_q, wen_q, load_q, tout_q;
  logic [31:0] addr_q, wdata_q, res_q, rdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [15:0] cnt_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        wb_q, fault_q;

  logic        is_mem, is_store, legal, illegal, in_idle;
  logic [31:0] al_wdata, al_load;
  logic [3:0]  al_be;

  assign in_idle  = (state_q == ST_IDLE);
  assign is_mem   = !ctrl_is_nop && (ctrl_mem_op == MEM_LOAD || ctrl_mem_op == MEM_STORE);
  assign is_store = (ctrl_mem_op == MEM_STORE);
  assign legal    = is_mem && mem_legal(is_store, ctrl_mem_funct3, res[1:0]);
  assign illegal  = is_mem && !legal;

  // store path needs the live slot in IDLE; load path needs the latched access later
  mem_lane_align u_align (
    .funct3_i     (in_idle ? ctrl_mem_funct3 : f3_q),
    .off_i        (in_idle ? res[1:0] : off_q),
    .store_data_i (store_data),
    .rdata_i      (rdata_q),
    .wdata_o      (al_wdata),
    .byte_en_o    (al_be),
    .load_data_o  (al_load)
  );

  // next-state: issue, wait for rdy or the wait limit, then release on pipeline advance
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: if (legal) state_d = ST_REQ;
      ST_REQ: begin
        if (dcache_rdy) begin
          state_d = ST_DONE;
        end else if (WAIT_LIMIT != 0 && cnt_q == LIM_C) begin
          state_d = ST_DONE;
          timeout = 1'b1;
        end
      end
      ST_DONE: if (!ctrl_stall) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_rst_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // latch the access on entry to REQ, count wait cycles, capture rdata on completion
  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_rst_n) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      req_q <= (state_d == ST_REQ);
      if (in_idle && legal) begin
        addr_q  <= {res[31:2], 2'b00};
        wen_q   <= is_store;
        be_q    <= is_store ? al_be : 4'b0000;
        wdata_q <= is_store ? al_wdata : 32'h0;
        f3_q    <= ctrl_mem_funct3;
        off_q   <= res[1:0];
        res_q   <= res;
        rd_q    <= rd;
        load_q  <= !is_store;
        cnt_q   <= '0;
        tout_q  <= 1'b0;
      end
      if (state_q == ST_REQ) begin
        cnt_q  <= cnt_q + 16'd1;
        tout_q <= timeout;
        if (dcache_rdy) rdata_q <= dcache_rdata;
      end
    end
  end

  // writeback registers advance only with the pipeline
  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_rst_n) begin
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_q      <= 1'b0;
      fault_q   <= 1'b0;
    end else if (!ctrl_stall) begin
      if (state_q == ST_DONE) begin
        wb_data_q <= (load_q && !tout_q) ? al_load : res_q;
        wb_rd_q   <= rd_q;
        wb_q      <= load_q && !tout_q;
        fault_q   <= tout_q;
      end else if (in_idle && !legal) begin
        wb_data_q <= res;
        wb_rd_q   <= rd;
        wb_q      <= ctrl_wb && !ctrl_is_nop && !illegal;
        fault_q   <= illegal;
      end
    end
  end

  assign ctrl_mem_stall     = (in_idle && legal) || (state_q == ST_REQ);
  assign dcache_req         = req_q;
  assign dcache_addr        = addr_q;
  assign dcache_wen         = wen_q;
  assign dcache_byte_en     = be_q;
  assign dcache_wdata       = wdata_q;
  assign wb_data_reg        = wb_data_q;
  assign wb_rd_reg          = wb_rd_q;
  assign ctrl_wb_reg        = wb_q;
  assign ctrl_mem_fault_reg = fault_q;

endmodule
